// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state codes,
// CRC-16-CCITT constants and the bit-serial CRC next-value function.
// Optional feature macro: CCFF_READBACK_EN (adds the VERIFY state code).
package ccff_pkg;

  typedef logic [2:0] ccff_state_t;

  localparam ccff_state_t ST_IDLE   = 3'd0;
  localparam ccff_state_t ST_CLEAR  = 3'd1;
  localparam ccff_state_t ST_LOAD   = 3'd2;
  localparam ccff_state_t ST_DONE   = 3'd3;
`ifdef CCFF_READBACK_EN
  localparam ccff_state_t ST_VERIFY = 3'd4;
`endif

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // MSB-first CRC-16-CCITT update with one serial input bit
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic data);
    logic fb;
    fb = crc[15] ^ data;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear and enable.
// Only present when CCFF_READBACK_EN is defined; the default build has no CRC.
`ifdef CCFF_READBACK_EN
module ccff_crc16 import ccff_pkg::*; (
  input  logic        CK,
  input  logic        RSTN,
  input  logic        clear,
  input  logic        enable,
  input  logic        data,
  output logic [15:0] crc
);

  // Restart from the CCITT seed on clear, fold in one bit per enabled cycle
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= crc16_next(crc, data);
    end
  end

endmodule
`endif

// File: rtl/ccff_loader.sv
// Configuration-chain loader: clears a DFFR scan chain, streams bitstream
// words into it LSB first with zero-bubble word handoff, and optionally
// recirculates the chain once to compare a readback CRC against the load CRC.
// Optional feature macro: CCFF_READBACK_EN (VERIFY state, two CRC units,
// sticky verify_err); without it verify_err is tied low.
module ccff_loader import ccff_pkg::*; #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_ce,
  output logic              chain_rst,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BUF_CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

  ccff_state_t          state;
  logic [WORD_W-1:0]    word_buf;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0]     bits_left;
  logic [CNT_W-1:0]     unbuffered;
  logic [BUF_CNT_W-1:0] fill_cnt;
  logic                 shifting;
  logic                 accept;
  logic                 last_shift;

  // bits_left counts bits still to shift in LOAD (and cycles left in VERIFY);
  // unbuffered is what future words still have to supply.
  assign shifting   = (state == ST_LOAD) && (buf_cnt != '0);
  assign last_shift = shifting && (bits_left == CNT_W'(1));
  assign unbuffered = bits_left - CNT_W'(buf_cnt);

  // A buffer holding only the bit being shifted now counts as empty, so the
  // next word can be taken in the same cycle and streaming has no bubble.
  assign din_ready  = (state == ST_LOAD) && (buf_cnt <= BUF_CNT_W'(1)) && (unbuffered != '0);
  assign accept     = din_ready && din_valid;

  // A word's valid bit count is capped by what the chain still needs, which
  // discards the unused high bits of the final word.
  always_comb begin
    fill_cnt = BUF_CNT_W'(WORD_W);
    if (32'(unbuffered) < 32'(WORD_W)) begin
      fill_cnt = BUF_CNT_W'(unbuffered);
    end
  end

  assign chain_rst = (state == ST_CLEAR);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

`ifdef CCFF_READBACK_EN
  logic        verifying;
  logic        verify_last;
  logic        crc_clear;
  logic        err_q;
  logic [15:0] crc_load;
  logic [15:0] crc_read;

  assign verifying   = (state == ST_VERIFY);
  assign verify_last = verifying && (bits_left == CNT_W'(1));
  assign crc_clear   = (state == ST_CLEAR);

  assign chain_ce  = (state == ST_CLEAR) || shifting || verifying;
  assign ccff_head = verifying ? ccff_tail : (shifting & word_buf[0]);

  ccff_crc16 u_crc_load (
    .CK     (CK),
    .RSTN   (RSTN),
    .clear  (crc_clear),
    .enable (shifting),
    .data   (ccff_head),
    .crc    (crc_load)
  );

  ccff_crc16 u_crc_read (
    .CK     (CK),
    .RSTN   (RSTN),
    .clear  (crc_clear),
    .enable (verifying),
    .data   (ccff_tail),
    .crc    (crc_read)
  );

  // Sticky mismatch flag: cleared by an accepted start, set on the last VERIFY
  // cycle using the readback CRC including the bit sampled in that cycle
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      err_q <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      err_q <= 1'b0;
    end else if (verify_last && (crc_load != crc16_next(crc_read, ccff_tail))) begin
      err_q <= 1'b1;
    end
  end

  assign verify_err = err_q;
`else
  logic unused_tail;

  assign unused_tail = ccff_tail;
  assign chain_ce    = (state == ST_CLEAR) || shifting;
  assign ccff_head   = shifting & word_buf[0];
  assign verify_err  = 1'b0;
`endif

  // Sequencer and word buffer: CLEAR one cycle, LOAD shifts CHAIN_LEN bits,
  // optional VERIFY recirculates CHAIN_LEN cycles, DONE pulses once
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      word_buf  <= '0;
      buf_cnt   <= '0;
      bits_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state     <= ST_LOAD;
          bits_left <= CHAIN_LEN_C;
          buf_cnt   <= '0;
        end
        ST_LOAD: begin
          if (shifting) begin
            word_buf  <= word_buf >> 1;
            buf_cnt   <= buf_cnt - BUF_CNT_W'(1);
            bits_left <= bits_left - CNT_W'(1);
          end
          if (accept) begin
            word_buf <= din;
            buf_cnt  <= fill_cnt;
          end
          if (last_shift) begin
`ifdef CCFF_READBACK_EN
            state     <= ST_VERIFY;
            bits_left <= CHAIN_LEN_C;
`else
            state     <= ST_DONE;
`endif
          end
        end
`ifdef CCFF_READBACK_EN
        ST_VERIFY: begin
          bits_left <= bits_left - CNT_W'(1);
          if (bits_left == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: two instances (64-cell and 20-cell
// chains, 8-bit words) each driving a behavioural DFFR chain model. A table of
// program runs (fixed and $urandom words, gapped and gapless streaming) is
// checked against the bitstream-level expectations, plus reset sequences.
// With CCFF_READBACK_EN defined, healthy and stuck-at readback rows are added.
module tb_ccff_loader;

  logic       CK = 1'b0;
  logic       RSTN;
  logic [1:0] start_v, valid_v, ready_v, head_v, tail_v, ce_v, crst_v, busy_v, done_v, err_v;
  logic [7:0] din_v [2];
  logic [63:0] chain [2];
  bit         stuck;
  int         vectors;
  int         miscompares;

  typedef struct {
    int          unit;
    int          nwords;
    logic [63:0] words;
    int          gap;
    bit          hold_start;
    bit          stuck;
    bit          exp_err;
  } vec_t;

`ifdef CCFF_READBACK_EN
  localparam int NV = 8;
  localparam bit RB = 1'b1;
`else
  localparam int NV = 6;
  localparam bit RB = 1'b0;
`endif

  vec_t tbl [8];

  always #5 CK = ~CK;

  ccff_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut64 (
    .CK(CK), .RSTN(RSTN), .start(start_v[0]), .din(din_v[0]), .din_valid(valid_v[0]),
    .din_ready(ready_v[0]), .ccff_head(head_v[0]), .ccff_tail(tail_v[0]), .chain_ce(ce_v[0]),
    .chain_rst(crst_v[0]), .busy(busy_v[0]), .done(done_v[0]), .verify_err(err_v[0])
  );

  ccff_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
    .CK(CK), .RSTN(RSTN), .start(start_v[1]), .din(din_v[1]), .din_valid(valid_v[1]),
    .din_ready(ready_v[1]), .ccff_head(head_v[1]), .ccff_tail(tail_v[1]), .chain_ce(ce_v[1]),
    .chain_rst(crst_v[1]), .busy(busy_v[1]), .done(done_v[1]), .verify_err(err_v[1])
  );

  // Behavioural DFFR chains: Q[0] takes head, tail is the last cell; cell 17
  // of the long chain can be forced stuck-at-1
  always @(posedge CK) begin
    for (int u = 0; u < 2; u++) begin
      if (ce_v[u]) begin
        chain[u] <= (crst_v[u] ? 64'h0 : {chain[u][62:0], head_v[u]})
                    | ((stuck && (u == 0)) ? 64'h20000 : 64'h0);
      end
    end
  end

  assign tail_v[0] = chain[0][63];
  assign tail_v[1] = chain[1][19];

  function automatic int chain_len(input int u);
    return (u == 0) ? 64 : 20;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkQuiet(input string tag, input int u);
    checkOutput({tag, "_ready"}, 64'(ready_v[u]), 64'd0);
    checkOutput({tag, "_head"},  64'(head_v[u]),  64'd0);
    checkOutput({tag, "_ce"},    64'(ce_v[u]),    64'd0);
    checkOutput({tag, "_rst"},   64'(crst_v[u]),  64'd0);
    checkOutput({tag, "_busy"},  64'(busy_v[u]),  64'd0);
    checkOutput({tag, "_done"},  64'(done_v[u]),  64'd0);
    checkOutput({tag, "_err"},   64'(err_v[u]),   64'd0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int u, L, widx, nload, nver, cyc, run, maxrun, pause, last_ce, done_cyc;
    int restarts, gap_bad, head_bad, need, exp_acc, exp_run;
    bit prev_ce, load_ce, seen_done;
    logic [63:0] got, mask, exp_chain;
    string t;
    u = v.unit; L = chain_len(u);
    t = $sformatf("t%0d", idx);
    widx = 0; nload = 0; nver = 0; cyc = 0; run = 0; maxrun = 0; pause = 0;
    last_ce = 0; done_cyc = 0; restarts = 0; gap_bad = 0; head_bad = 0;
    prev_ce = 1'b0; seen_done = 1'b0; got = '0;
    stuck = v.stuck;
    @(negedge CK);
    checkOutput({t, "_idle_busy"}, 64'(busy_v[u]), 64'd0);
    start_v[u] = 1'b1;
    @(negedge CK);
    start_v[u] = v.hold_start;
    checkOutput({t, "_clear_rst"},  64'(crst_v[u]), 64'd1);
    checkOutput({t, "_clear_ce"},   64'(ce_v[u]),   64'd1);
    checkOutput({t, "_clear_busy"}, 64'(busy_v[u]), 64'd1);
    while (!seen_done && cyc < 3000) begin
      @(negedge CK);
      cyc++;
      if (done_v[u]) begin
        seen_done = 1'b1;
        done_cyc = cyc;
        start_v[u] = 1'b0;
        valid_v[u] = 1'b0;
      end else begin
        if (crst_v[u]) restarts++;
        load_ce = 1'b0;
        if (ce_v[u]) begin
          last_ce = cyc;
          if (nload < L) begin
            got[nload] = head_v[u];
            nload++;
            load_ce = 1'b1;
            run = prev_ce ? run + 1 : 1;
            if (run > maxrun) maxrun = run;
            prev_ce = 1'b1;
          end else begin
            nver++;
            if (head_v[u] !== tail_v[u]) head_bad++;
            prev_ce = 1'b0;
          end
        end else begin
          prev_ce = 1'b0;
        end
        if (pause > 0) begin
          if (pause <= v.gap && load_ce) gap_bad++;
          pause--;
          valid_v[u] = 1'b0;
        end else if (widx < v.nwords) begin
          valid_v[u] = 1'b1;
          din_v[u] = v.words[8*widx +: 8];
        end else begin
          valid_v[u] = 1'b0;
        end
        if (valid_v[u] && ready_v[u]) begin
          widx++;
          if (v.gap > 0) pause = 8 + v.gap;
        end
      end
    end
    valid_v[u] = 1'b0;
    need = (L + 7) / 8;
    exp_acc = (v.nwords < need) ? v.nwords : need;
    exp_run = (v.gap == 0) ? L : ((L < 8) ? L : 8);
    mask = (L == 64) ? '1 : ((64'd1 << L) - 64'd1);
    exp_chain = '0;
    for (int i = 0; i < L; i++) exp_chain[L-1-i] = v.words[i];
    checkOutput({t, "_done_seen"},  64'(seen_done), 64'd1);
    checkOutput({t, "_done_busy"},  64'(busy_v[u]),  64'd1);
    checkOutput({t, "_done_err"},   64'(err_v[u]),   64'(v.exp_err));
    checkOutput({t, "_shifts"},     64'(nload),      64'(L));
    checkOutput({t, "_verify_cyc"}, 64'(nver),       RB ? 64'(L) : 64'd0);
    checkOutput({t, "_done_lat"},   64'(done_cyc - last_ce), 64'd1);
    checkOutput({t, "_max_run"},    64'(maxrun),     64'(exp_run));
    checkOutput({t, "_accepted"},   64'(widx),       64'(exp_acc));
    checkOutput({t, "_gap_ce"},     64'(gap_bad),    64'd0);
    checkOutput({t, "_restart"},    64'(restarts),   64'd0);
    checkOutput({t, "_recirc"},     64'(head_bad),   64'd0);
    checkOutput({t, "_head_bits"},  got & mask,      v.words & mask);
    if (!v.stuck) checkOutput({t, "_chain"}, chain[u] & mask, exp_chain);
    @(negedge CK);
    checkOutput({t, "_done_pulse"}, 64'(done_v[u]),  64'd0);
    checkOutput({t, "_idle_busy2"}, 64'(busy_v[u]),  64'd0);
    checkOutput({t, "_idle_ready"}, 64'(ready_v[u]), 64'd0);
    stuck = 1'b0;
  endtask

  task automatic resetMidLoad();
    @(negedge CK);
    start_v[0] = 1'b1;
    @(negedge CK);
    start_v[0] = 1'b0;
    valid_v[0] = 1'b1;
    din_v[0] = 8'hA5;
    repeat (6) @(negedge CK);
    checkOutput("rst_mid_ce", 64'(ce_v[0]), 64'd1);
    RSTN = 1'b0;
    valid_v[0] = 1'b0;
    #1;
    checkQuiet("rst_mid", 0);
    #2;
    RSTN = 1'b1;
    @(negedge CK);
    checkOutput("rst_after_busy",  64'(busy_v[0]),  64'd0);
    checkOutput("rst_after_ready", 64'(ready_v[0]), 64'd0);
    checkOutput("rst_after_ce",    64'(ce_v[0]),    64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RSTN = 1'b0;
    start_v = '0;
    valid_v = '0;
    din_v[0] = '0;
    din_v[1] = '0;
    stuck = 1'b0;

    tbl[0] = '{unit: 0, nwords: 8, words: 64'h0807060504030201, gap: 0, hold_start: 0, stuck: 0, exp_err: 0};
    tbl[1] = '{unit: 1, nwords: 3, words: 64'h0000000000FF55AA, gap: 0, hold_start: 0, stuck: 0, exp_err: 0};
    tbl[2] = '{unit: 0, nwords: 8, words: 64'h0807060504030201, gap: 5, hold_start: 1, stuck: 0, exp_err: 0};
    tbl[3] = '{unit: 1, nwords: 3, words: 64'h0000000000FF55AA, gap: 5, hold_start: 0, stuck: 0, exp_err: 0};
    tbl[4] = '{unit: 0, nwords: 8, words: {$urandom, $urandom}, gap: 0, hold_start: 1, stuck: 0, exp_err: 0};
    tbl[5] = '{unit: 1, nwords: 4, words: {32'h0, $urandom}, gap: 2, hold_start: 1, stuck: 0, exp_err: 0};
    tbl[6] = '{unit: 0, nwords: 8, words: 64'h0807060504030201, gap: 0, hold_start: 0, stuck: 1, exp_err: 1};
    tbl[7] = '{unit: 0, nwords: 8, words: {$urandom, $urandom}, gap: 0, hold_start: 0, stuck: 0, exp_err: 0};

    #3;
    checkQuiet("por_u0", 0);
    checkQuiet("por_u1", 1);
    @(negedge CK);
    #2;
    RSTN = 1'b1;

    for (int i = 0; i < NV; i++) applyStimulus(i, tbl[i]);
    resetMidLoad();
    applyStimulus(99, tbl[0]);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, giving the number of DFFR cells in the driven configuration chain (range 2..65535).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream input word width (range 1..32).
REQ-003 SHALL have port CK  input  1  as its single clock; all state updates on the rising edge.
REQ-004 SHALL have port RSTN  input  1  as its reset, which is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  to request a chain program when the block is idle.
REQ-006 SHALL have port din  input  WORD_W  carrying bitstream words.
REQ-007 SHALL have port din_valid  input  1  to qualify din.
REQ-008 SHALL have port din_ready  output  1  to accept din when both din_valid and din_ready are high.
REQ-009 SHALL have port ccff_head  output  1  driving D of the first chain cell.
REQ-010 SHALL have port ccff_tail  input  1  taken from Q of the last chain cell.
REQ-011 SHALL have port chain_ce  output  1  as the chain clock enable; the chain captures on a CK edge only when chain_ce is high.
REQ-012 SHALL have port chain_rst  output  1  driving the active-high synchronous RST of all chain cells.
REQ-013 SHALL have port busy  output  1  high from start acceptance until done.
REQ-014 SHALL have port done  output  1  as a one-cycle pulse on completion.
REQ-015 SHALL have port verify_err  output  1  as a sticky readback-mismatch flag.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, LOAD, VERIFY, DONE.
REQ-017 In IDLE, start=1 SHALL move to CLEAR next cycle and clear verify_err; start in other states SHALL be ignored.
REQ-018 CLEAR SHALL last exactly 1 cycle with chain_rst=1 and chain_ce=1, then go to LOAD.
REQ-019 LOAD SHALL assert din_ready only while the internal word buffer is empty and bits remain to load.
REQ-020 Each accepted word SHALL be shifted out LSB first, one bit per cycle on ccff_head, with chain_ce=1 in that same cycle.
REQ-021 A new word SHALL be acceptable in the cycle its predecessor's last bit shifts, giving zero-bubble streaming (a full word takes WORD_W cycles).
REQ-022 If din_valid is low with the buffer empty, chain_ce SHALL be 0 and the chain SHALL hold.
REQ-023 The bit counter SHALL count exactly CHAIN_LEN shifted bits; unused high bits of the final word SHALL be discarded.
REQ-024 After bit CHAIN_LEN, the FSM SHALL go to VERIFY when readback is compiled in, otherwise to DONE.
REQ-025 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-026 Outside CLEAR and shifting cycles, chain_ce, chain_rst and ccff_head SHALL be 0.

Reset
REQ-027 RSTN low SHALL force IDLE immediately, and din_ready, ccff_head, chain_ce, chain_rst, busy, done and verify_err SHALL all be 0.
REQ-028 Reset mid-LOAD SHALL abandon the word buffer and counters; the chain contents are then undefined until the next start.

Configuration
REQ-029 With CCFF_READBACK_EN defined, the block SHALL include the VERIFY state and CRC-16-CCITT (init 0xFFFF) computation.
- LOAD: CRC of every ccff_head bit shifted.
- VERIFY: CHAIN_LEN cycles with chain_ce=1 and ccff_head=ccff_tail (recirculate, chain contents preserved), CRC of ccff_tail sampled each cycle.
- End of VERIFY: unequal CRCs SHALL set verify_err before done pulses.
REQ-030 Without CCFF_READBACK_EN, the block SHALL have no VERIFY state or CRC logic, and verify_err SHALL be tied 0.

Structure
REQ-031 The state enum, CRC polynomial/init constants and the CRC next-value function SHALL live in a shared package ccff_pkg.
REQ-032 The CRC update SHALL be a sub-module ccff_crc16 (bit-serial, clear/enable), instantiated twice under CCFF_READBACK_EN.

Verification
REQ-033 Reset: RSTN=0 mid-LOAD -> all outputs 0 in the same cycle; IDLE after release.
REQ-034 CHAIN_LEN=64, WORD_W=8, 8 back-to-back words 0x01..0x08 -> chain_ce high 64 consecutive cycles; chain Q[0..63] equals the bitstream LSB-first; done 1 cycle later.
REQ-035 CHAIN_LEN=20, WORD_W=8, words 0xAA,0x55,0xFF -> exactly 20 shifts; the high nibble of 0xFF is discarded; done pulses.
REQ-036 din_valid gapped 5 cycles between words -> chain_ce low throughout the gaps; final chain contents identical to the gapless run.
REQ-037 CCFF_READBACK_EN with a healthy chain model -> VERIFY lasts 64 cycles, verify_err=0, and chain contents are unchanged.
REQ-038 CCFF_READBACK_EN with chain bit 17 stuck-at-1 and loaded 0 -> verify_err=1 at done.
